// File: rtl/wb_posted_bus_if.sv
// Wishbone master bridge with a posted-write FIFO, bus-error and timeout
// reporting, and read ordering behind buffered writes.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   hold_i, flush_i    pipeline hold and flush from CTRL
//   cpu_*_i            access request (ce, we, addr, data, sel)
//   cpu_data_o         read data to the pipeline
//   stallreq_o         stall request to CTRL
//   bus_err_o          one-cycle pulse after a bus error or timeout
//   wbuf_count_o       occupied write-buffer entries
//   wishbone_*         Wishbone master signals

module wb_posted_bus_if #(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int WBUF_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hold_i,
    input  logic                        flush_i,
    input  logic                        cpu_ce_i,
    input  logic                        cpu_we_i,
    input  logic [AW-1:0]               cpu_addr_i,
    input  logic [DW-1:0]               cpu_data_i,
    input  logic [DW/8-1:0]             cpu_sel_i,
    output logic [DW-1:0]               cpu_data_o,
    output logic                        stallreq_o,
    output logic                        bus_err_o,
    output logic [$clog2(WBUF_DEPTH):0] wbuf_count_o,
    input  logic [DW-1:0]               wishbone_data_i,
    input  logic                        wishbone_ack_i,
    input  logic                        wishbone_err_i,
    output logic [AW-1:0]               wishbone_addr_o,
    output logic [DW-1:0]               wishbone_data_o,
    output logic                        wishbone_we_o,
    output logic [DW/8-1:0]             wishbone_sel_o,
    output logic                        wishbone_stb_o,
    output logic                        wishbone_cyc_o
);

    localparam int SW = DW / 8;
    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WBUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        HOLD
    } state_t;

    state_t state;

    logic [AW-1:0] fifo_addr [WBUF_DEPTH];
    logic [DW-1:0] fifo_data [WBUF_DEPTH];
    logic [SW-1:0] fifo_sel  [WBUF_DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [TW-1:0] to_cnt;
    logic [DW-1:0] rd_data;

    logic full;
    logic empty;
    logic busy;
    logic timeout;
    logic done;
    logic push;
    logic pop;

    // full comes from the registered count only, so a pop in the
    // same cycle never lets a push through.
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign busy  = (state == WRITE) || (state == READ);

    assign timeout = TO_EN && busy && (to_cnt == TO_LAST)
                     && !wishbone_ack_i && !wishbone_err_i;

    assign done = busy && (wishbone_ack_i || wishbone_err_i || timeout);

    assign push = cpu_ce_i && cpu_we_i && !flush_i && !hold_i && !full;
    assign pop  = (state == WRITE) && done;

    assign wbuf_count_o = count;

    // Reads stall until they complete on the bus; HOLD releases the
    // stage because the captured data is already in rd_data.
    assign stallreq_o = (cpu_ce_i && cpu_we_i && full)
                        || (cpu_ce_i && !cpu_we_i && !flush_i
                            && !((state == READ) && done)
                            && (state != HOLD));

    always_comb begin
        cpu_data_o = rd_data;
        if ((state == READ) && wishbone_ack_i) begin
            cpu_data_o = wishbone_data_i;
        end else if ((state == READ) && done) begin
            cpu_data_o = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cpu_addr_i;
            fifo_data[wr_ptr] <= cpu_data_i;
            fifo_sel[wr_ptr]  <= cpu_sel_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            to_cnt          <= '0;
            rd_data         <= '0;
            bus_err_o       <= 1'b0;
            wishbone_cyc_o  <= 1'b0;
            wishbone_stb_o  <= 1'b0;
            wishbone_we_o   <= 1'b0;
            wishbone_addr_o <= '0;
            wishbone_data_o <= '0;
            wishbone_sel_o  <= '0;
        end else begin
            // ack wins over a simultaneous err
            bus_err_o <= busy && !wishbone_ack_i
                         && (wishbone_err_i || timeout);

            unique case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (!empty) begin
                        state           <= WRITE;
                        wishbone_cyc_o  <= 1'b1;
                        wishbone_stb_o  <= 1'b1;
                        wishbone_we_o   <= 1'b1;
                        wishbone_addr_o <= fifo_addr[rd_ptr];
                        wishbone_data_o <= fifo_data[rd_ptr];
                        wishbone_sel_o  <= fifo_sel[rd_ptr];
                    end else if (cpu_ce_i && !cpu_we_i && !flush_i) begin
                        state           <= READ;
                        wishbone_cyc_o  <= 1'b1;
                        wishbone_stb_o  <= 1'b1;
                        wishbone_we_o   <= 1'b0;
                        wishbone_addr_o <= cpu_addr_i;
                        wishbone_data_o <= '0;
                        wishbone_sel_o  <= cpu_sel_i;
                    end
                end

                WRITE: begin
                    to_cnt <= to_cnt + TW'(1);
                    if (done) begin
                        state           <= IDLE;
                        wishbone_cyc_o  <= 1'b0;
                        wishbone_stb_o  <= 1'b0;
                        wishbone_we_o   <= 1'b0;
                        wishbone_addr_o <= '0;
                        wishbone_data_o <= '0;
                        wishbone_sel_o  <= '0;
                    end
                end

                READ: begin
                    to_cnt <= to_cnt + TW'(1);
                    if (done) begin
                        rd_data <= wishbone_ack_i ? wishbone_data_i : '0;
                    end
                    // A flush abandons the read; a late ack lands in
                    // IDLE and is ignored there.
                    if (flush_i || done) begin
                        state           <= (hold_i && !flush_i) ? HOLD : IDLE;
                        wishbone_cyc_o  <= 1'b0;
                        wishbone_stb_o  <= 1'b0;
                        wishbone_we_o   <= 1'b0;
                        wishbone_addr_o <= '0;
                        wishbone_data_o <= '0;
                        wishbone_sel_o  <= '0;
                    end
                end

                HOLD: begin
                    if (!hold_i || flush_i) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_posted_bus_if.md
# wb_posted_bus_if

Parametrised single-clock Wishbone master bridge for the MiniMIPS32 instruction and data ports, and the successor to the current bus interface. It adds a configurable posted-write buffer, configurable data and address widths, bus-error and timeout reporting, and read ordering behind buffered writes. It sits between the MEM (or IF) stage and the Wishbone fabric, and stalls the pipeline through CTRL via `stallreq_o`.

## Interface
- DW, 32, data width; a multiple of 8.
- AW, 32, address width.
- WBUF_DEPTH, 4, write-buffer entries; a power of 2, at least 2.
- TIMEOUT, 255, cycles to wait for ack/err before aborting; 0 disables the timeout.

- clk  in  1  clock. One clock only.
- rst  in  1  reset. Asynchronous, active-high.
- hold_i  in  1  the requesting pipeline stage is held this cycle (CTRL stall bit).
- flush_i  in  1  pipeline flush.
- cpu_ce_i  in  1  access request.
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_addr_i  in  AW  access address.
- cpu_data_i  in  DW  write data.
- cpu_sel_i  in  DW/8  byte lane selects.
- cpu_data_o  out  DW  read data.
- stallreq_o  out  1  stall request to CTRL.
- bus_err_o  out  1  one-cycle pulse on err_i or timeout.
- wbuf_count_o  out  log2(WBUF_DEPTH)+1  number of occupied buffer entries.
- wishbone_data_i  in  DW  bus read data.
- wishbone_ack_i  in  1  bus acknowledge.
- wishbone_err_i  in  1  bus error.
- wishbone_addr_o  out  AW  bus address.
- wishbone_data_o  out  DW  bus write data.
- wishbone_we_o  out  1  bus write enable.
- wishbone_sel_o  out  DW/8  bus byte selects.
- wishbone_stb_o  out  1  bus strobe.
- wishbone_cyc_o  out  1  bus cycle.

## Operation
- Reset: state IDLE; FIFO pointers and count 0; cpu_data_o and rd_data 0; all wishbone_* outputs 0; stallreq_o and bus_err_o 0.
- Write push:
  - Condition: cpu_ce_i & cpu_we_i & !flush_i & !hold_i & !full.
  - Pushes {addr, data, sel} into the FIFO.
  - full is derived from the registered count only. A pop in the same cycle does not unblock a push.
  - A simultaneous push and pop leaves the count unchanged.
- Write stall: stallreq_o = cpu_ce_i & cpu_we_i & full.
- Buffered writes are committed. flush_i never discards them.
- State machine:
  - IDLE:
    - If the buffer is non-empty, go to WRITE and drive the head entry (we=1).
    - Else, if cpu_ce_i & !cpu_we_i & !flush_i, go to READ (we=0, sel=cpu_sel_i, addr=cpu_addr_i).
  - WRITE: cyc/stb held with the head entry.
    - On ack: pop and go to IDLE.
    - On err or timeout: pop, pulse bus_err_o, go to IDLE.
  - READ: cyc/stb held.
    - On ack: rd_data <= wishbone_data_i.
    - On err or timeout: rd_data <= 0 and pulse bus_err_o.
    - After completion, go to HOLD if hold_i is high, else IDLE.
    - flush_i in READ drops cyc/stb in the next cycle and goes to IDLE. The read is abandoned and a late ack is ignored.
  - HOLD: no bus activity. cpu_data_o = rd_data. Go to IDLE when hold_i is low. flush_i also returns the block to IDLE.
- Read ordering: a read never starts while the buffer is non-empty or the state is WRITE. The read stalls until all writes drain.
- Read stall: stallreq_o = cpu_ce_i & !cpu_we_i & !flush_i & !(READ & (ack | err | timeout)) & state != HOLD.
- cpu_data_o selection:
  - wishbone_data_i in the READ ack cycle.
  - 0 in a READ err/timeout cycle.
  - rd_data otherwise.
- Timeout counter:
  - Cleared on entry to WRITE or READ; increments each cycle in those states.
  - Timeout fires when count == TIMEOUT-1 with no ack or err.
  - If ack and err arrive together, ack wins.
- wishbone_* outputs are registered, except that cyc/stb/we/addr/data/sel reflect the current state. All are 0 in IDLE and HOLD.

## Timing
- Write, zero-wait slave:
  - Push at cycle 0; count=1 at cycle 1.
  - WRITE with stb high at cycle 2; ack at cycle 2.
  - Count=0 and IDLE at cycle 3. The CPU is never stalled.
- Back-to-back writes: one IDLE cycle between bus transactions, so sustained throughput is 1 write per 2 cycles plus slave wait states.
- Read, empty buffer, zero-wait slave:
  - Request at cycle 0 (stallreq_o=1); stb high at cycle 1.
  - Ack at cycle 1: data on cpu_data_o and stallreq_o=0 in cycle 1.
  - Minimum one stall cycle.
- Read behind N buffered writes: stalls for N×(2 + slave wait) cycles, plus the read latency.
- Reset mid-transaction: cyc/stb drop asynchronously and the buffer contents are lost.

## Test plan
- Single write to 0x0000_0100, data 0xA5A5_5A5A, sel 4'hF, slave ack at first stb -> stb/we high exactly at cycle 2, stallreq_o never 1, wbuf_count_o 1→0.
- Five consecutive writes with WBUF_DEPTH=4 and slave wait 3 cycles -> the 5th write raises stallreq_o until the first pop + 1 cycle, and all 5 appear on the bus in order.
- Two writes then a read of 0x0000_0200, slave returns 0x1234_5678 -> the read stb asserts only after the 2nd write's ack; cpu_data_o = 0x1234_5678 in the ack cycle; stallreq_o low the same cycle.
- Read acked while hold_i=1 for 3 cycles -> HOLD for 3 cycles, cpu_data_o held, no second bus read, IDLE when hold_i falls.
- Read with slave silent and TIMEOUT=8 -> cyc/stb drop after 8 cycles, bus_err_o pulses once, cpu_data_o=0, stallreq_o released. Separately, err_i on a write -> entry popped and bus_err_o pulses.
- flush_i during a pending read with one buffered write -> the write still completes on the bus, the read never issues, and stallreq_o is 0 during the flush.
